// File: rtl/servgrid_host_pkg.sv
// Shared encodings for the servgrid Wishbone host: FSM states and address-field layout.
// Imported by the host top; the command FIFO is generic and takes no types from here.
package servgrid_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int TILE_LSB    = 16;
  localparam int LOCAL_ADR_W = 16;
  localparam int WB_DAT_W    = 32;
  localparam int WB_SEL_W    = 4;

endpackage

// File: rtl/servgrid_host_fifo.sv
// Synchronous FIFO with full/empty flags; zero-latency head, push-at-full allowed only with a same-cycle pop.
// Backpressure: a push while full without a pop is dropped; a pop while empty is ignored.
module servgrid_host_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is left unreset; contents are only observed behind the empty flag.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/servgrid_wb_host.sv
// Queued command stream to single-beat Wishbone cycles on the servgrid proc port; stb 2 cycles after accept, bounded ack wait.
// Backpressure: cmd_ready drops when the queue is full; a response is held until rsp_ready, stalling the next command.
module servgrid_wb_host
  import servgrid_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int TILE_BITS  = 4
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [TILE_BITS-1:0] cmd_tile,
  input  logic [15:0]          cmd_adr,
  input  logic [31:0]          cmd_dat,
  input  logic [3:0]           cmd_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic [31:0]          o_wb_proc_adr,
  output logic [31:0]          o_wb_proc_dat,
  output logic [3:0]           o_wb_proc_sel,
  output logic                 o_wb_proc_we,
  output logic                 o_wb_proc_stb,
  input  logic [31:0]          i_wb_proc_rdt,
  input  logic                 i_wb_proc_ack,
  output logic                 busy
);

  localparam int CW = 1 + TILE_BITS + LOCAL_ADR_W + WB_DAT_W + WB_SEL_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic [31:0]            r_adr;
  logic [31:0]            r_dat;
  logic [3:0]             r_sel;
  logic                   r_we;
  logic                   r_stb;
  logic                   r_rsp_vld;
  logic [31:0]            r_rsp_dat;
  logic                   r_rsp_err;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_push_dat;
  logic [CW-1:0]          w_head;
  logic                   w_h_we;
  logic [TILE_BITS-1:0]   w_h_tile;
  logic [15:0]            w_h_adr;
  logic [31:0]            w_h_dat;
  logic [3:0]             w_h_sel;
  logic [31:0]            w_bus_adr;

  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_push_dat = {cmd_we, cmd_tile, cmd_adr, cmd_dat, cmd_sel};

  servgrid_host_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk),
    .i_rst_n (wb_rst_n),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_h_we   = w_head[CW-1];
  assign w_h_tile = w_head[CW-2 -: TILE_BITS];
  assign w_h_adr  = w_head[WB_DAT_W+WB_SEL_W +: LOCAL_ADR_W];
  assign w_h_dat  = w_head[WB_SEL_W +: WB_DAT_W];
  assign w_h_sel  = w_head[WB_SEL_W-1:0];

  // Bits above the tile field stay zero so the fabric decodes only tile + local address.
  always_comb begin
    w_bus_adr                               = '0;
    w_bus_adr[TILE_LSB +: TILE_BITS]        = w_h_tile;
    w_bus_adr[LOCAL_ADR_W-1:0]              = w_h_adr;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_stb     <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_adr   <= w_bus_adr;
            r_dat   <= w_h_dat;
            r_sel   <= w_h_sel;
            r_we    <= w_h_we;
            r_stb   <= 1'b1;
            r_timer <= '0;
            r_state <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is checked first so an ack in the last allowed cycle still succeeds.
          if (i_wb_proc_ack) begin
            r_rsp_dat <= r_we ? 32'd0 : i_wb_proc_rdt;
            r_rsp_err <= 1'b0;
            r_rsp_vld <= 1'b1;
            r_stb     <= 1'b0;
            r_state   <= ST_RESP;
          end else if (r_timer == T_LAST) begin
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b1;
            r_rsp_vld <= 1'b1;
            r_stb     <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_proc_adr = r_adr;
  assign o_wb_proc_dat = r_dat;
  assign o_wb_proc_sel = r_sel;
  assign o_wb_proc_we  = r_we;
  assign o_wb_proc_stb = r_stb;
  assign rsp_valid     = r_rsp_vld;
  assign rsp_dat       = r_rsp_dat;
  assign rsp_err       = r_rsp_err;
  assign busy          = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_servgrid_wb_host.sv
// Scoreboard bench for servgrid_wb_host: directed commands queue expected bus and response values,
// a bus monitor/responder and a response monitor compare independently.
`timescale 1ns/1ps
module tb_servgrid_wb_host;

  localparam int TIMEOUT = 8;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_tile;
  logic [15:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] o_wb_proc_adr, o_wb_proc_dat, i_wb_proc_rdt;
  logic [3:0]  o_wb_proc_sel;
  logic        o_wb_proc_we, o_wb_proc_stb, i_wb_proc_ack, busy;

  always #5 wb_clk = ~wb_clk;

  servgrid_wb_host #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT),
    .TILE_BITS  (4)
  ) dut (
    .wb_clk        (wb_clk),
    .wb_rst_n      (wb_rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_tile      (cmd_tile),
    .cmd_adr       (cmd_adr),
    .cmd_dat       (cmd_dat),
    .cmd_sel       (cmd_sel),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_dat       (rsp_dat),
    .rsp_err       (rsp_err),
    .o_wb_proc_adr (o_wb_proc_adr),
    .o_wb_proc_dat (o_wb_proc_dat),
    .o_wb_proc_sel (o_wb_proc_sel),
    .o_wb_proc_we  (o_wb_proc_we),
    .o_wb_proc_stb (o_wb_proc_stb),
    .i_wb_proc_rdt (i_wb_proc_rdt),
    .i_wb_proc_ack (i_wb_proc_ack),
    .busy          (busy)
  );

  typedef struct {
    logic        we;
    logic [3:0]  tile;
    logic [15:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          ack_at;
    logic [31:0] rdat;
    logic [31:0] exp_adr;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_dat;
  } txn_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  txn_t bus_q[$];
  rsp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   in_reset = 1'b0;
  bit   spur_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [3:0] tile, input logic [15:0] adr,
                              input logic [31:0] wdat, input logic [3:0] sel, input int ack_at,
                              input logic [31:0] rdat, input logic [31:0] exp_adr, input int exp_stb,
                              input logic exp_err, input logic [31:0] exp_dat);
    txn_t t;
    t.we = we; t.tile = tile; t.adr = adr; t.wdat = wdat; t.sel = sel;
    t.ack_at = ack_at; t.rdat = rdat; t.exp_adr = exp_adr; t.exp_stb = exp_stb;
    t.exp_err = exp_err; t.exp_dat = exp_dat;
    return t;
  endfunction

  task automatic send(input txn_t t);
    rsp_t r;
    bit   ok;
    ok = 1'b0;
    r.err = t.exp_err;
    r.dat = t.exp_dat;
    bus_q.push_back(t);
    rsp_q.push_back(r);
    @(negedge wb_clk);
    cmd_we = t.we; cmd_tile = t.tile; cmd_adr = t.adr; cmd_dat = t.wdat; cmd_sel = t.sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      @(negedge wb_clk);
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready never high, adr 0x%08h", t.exp_adr);
    end
  endtask

  task automatic set_rdy(input logic v);
    @(posedge wb_clk);
    #1 rsp_ready = v;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge wb_clk);
      ok = !busy && !rsp_valid && (rsp_q.size() == 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b rsp_valid=%0b pending=%0d after %0d cycles",
               busy, rsp_valid, rsp_q.size(), budget);
    end
  endtask

  task automatic wait_rsp(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge wb_clk);
      ok = rsp_valid;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_wait_timeout: rsp_valid low after %0d cycles", budget);
    end
  endtask

  // Bus monitor and responder: checks fields at stb rise, drives ack on the scheduled stb cycle.
  initial begin : bus_mon
    txn_t cur;
    bit   active;
    bit   spur;
    int   cnt;
    active = 1'b0; spur = 1'b0; cnt = 0;
    i_wb_proc_ack = 1'b0;
    i_wb_proc_rdt = 32'd0;
    forever begin
      @(negedge wb_clk);
      if (o_wb_proc_stb) begin
        if (!active) begin
          cnt = 1;
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_stb: adr 0x%08h with no command pending", o_wb_proc_adr);
          end else begin
            cur = bus_q.pop_front();
            active = 1'b1;
            check("bus_adr", o_wb_proc_adr, cur.exp_adr);
            check("bus_we", 32'(o_wb_proc_we), 32'(cur.we));
            check("bus_dat", o_wb_proc_dat, cur.wdat);
            check("bus_sel", 32'(o_wb_proc_sel), 32'(cur.sel));
          end
        end else begin
          cnt++;
        end
        if (active && cur.ack_at == cnt) begin
          i_wb_proc_ack = 1'b1;
          i_wb_proc_rdt = cur.rdat;
        end else begin
          i_wb_proc_ack = 1'b0;
          i_wb_proc_rdt = 32'hBAD0_0BAD;
        end
      end else begin
        if (active) begin
          if (!in_reset) check("stb_cycles", 32'(cnt), 32'(cur.exp_stb));
          active = 1'b0;
        end
        spur = spur_en ? ~spur : 1'b0;
        i_wb_proc_ack = spur;
        i_wb_proc_rdt = 32'hFFFF_0000;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake and checks hold-stability while stalled.
  initial begin : rsp_mon
    rsp_t        e;
    bit          hold;
    logic [31:0] hd;
    logic        he;
    hold = 1'b0; hd = '0; he = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (hold && rsp_valid) begin
        check("rsp_hold_dat", rsp_dat, hd);
        check("rsp_hold_err", 32'(rsp_err), 32'(he));
      end
      hold = rsp_valid && !rsp_ready;
      hd = rsp_dat;
      he = rsp_err;
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got dat=0x%08h err=%0b with none expected", rsp_dat, rsp_err);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_dat", rsp_dat, e.dat);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    txn_t t;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_tile = '0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1;
    wb_rst_n = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_adr", o_wb_proc_adr, 32'd0);
    check("rst_wdat", o_wb_proc_dat, 32'd0);
    check("rst_sel", 32'(o_wb_proc_sel), 32'd0);
    check("rst_we", 32'(o_wb_proc_we), 32'd0);
    check("rst_stb", 32'(o_wb_proc_stb), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;

    // Basic write, read, timeout, ack on the last allowed cycle, write with partial sel.
    send(mk(1'b1, 4'h3, 16'h0100, 32'hDEAD_BEEF, 4'hF, 2, 32'h5555_AAAA, 32'h0003_0100, 2, 1'b0, 32'h0));
    wait_idle(100);
    send(mk(1'b0, 4'h5, 16'h0004, 32'h0, 4'hF, 3, 32'h1234_5678, 32'h0005_0004, 3, 1'b0, 32'h1234_5678));
    wait_idle(100);
    send(mk(1'b0, 4'hA, 16'hFFFC, 32'h0, 4'hF, 0, 32'h0, 32'h000A_FFFC, 8, 1'b1, 32'h0));
    wait_idle(100);
    send(mk(1'b0, 4'h1, 16'h0010, 32'h0, 4'hF, 8, 32'hCAFE_F00D, 32'h0001_0010, 8, 1'b0, 32'hCAFE_F00D));
    wait_idle(100);
    send(mk(1'b1, 4'hF, 16'h8000, 32'h0BAD_F00D, 4'h3, 1, 32'hAAAA_5555, 32'h000F_8000, 1, 1'b0, 32'h0));
    wait_idle(100);

    // Fill: response stalled, one command in the FSM plus four in the queue.
    set_rdy(1'b0);
    for (int i = 0; i < 5; i++) begin
      t = mk(1'b0, 4'(i + 1), 16'(16'h0040 * i), 32'h0000_1111 * i, 4'hF, 1, 32'hA500_0000 | 32'(i),
             32'h0001_0000 * (i + 1) + 32'h40 * i, 1, 1'b0, 32'hA500_0000 | 32'(i));
      send(t);
    end
    repeat (3) @(negedge wb_clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    set_rdy(1'b1);
    send(mk(1'b0, 4'h6, 16'h0140, 32'h0000_5555, 4'hF, 1, 32'hA500_0005, 32'h0006_0140, 1, 1'b0, 32'hA500_0005));
    wait_idle(300);

    // Reset while a cycle is on the bus and two commands are queued.
    send(mk(1'b0, 4'h2, 16'h0200, 32'h0, 4'hF, 0, 32'h0, 32'h0002_0200, 8, 1'b1, 32'h0));
    send(mk(1'b1, 4'h2, 16'h0204, 32'h1, 4'hF, 1, 32'h0, 32'h0002_0204, 1, 1'b0, 32'h0));
    send(mk(1'b1, 4'h2, 16'h0208, 32'h2, 4'hF, 1, 32'h0, 32'h0002_0208, 1, 1'b0, 32'h0));
    check("pre_rst_stb", 32'(o_wb_proc_stb), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge wb_clk);
    #3;
    in_reset = 1'b1;
    bus_q.delete();
    rsp_q.delete();
    wb_rst_n = 1'b0;
    #1;
    check("arst_stb", 32'(o_wb_proc_stb), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(posedge wb_clk);
    #1 in_reset = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge wb_clk);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_stb", 32'(o_wb_proc_stb), 32'd0);

    // Spurious acks in IDLE and while a response is stalled in RESP.
    @(posedge wb_clk);
    #1 spur_en = 1'b1;
    repeat (6) @(negedge wb_clk);
    check("spur_idle_busy", 32'(busy), 32'd0);
    check("spur_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("spur_idle_stb", 32'(o_wb_proc_stb), 32'd0);
    set_rdy(1'b0);
    send(mk(1'b1, 4'h7, 16'h0ABC, 32'h7777_0001, 4'h8, 2, 32'h9999_9999, 32'h0007_0ABC, 2, 1'b0, 32'h0));
    wait_rsp(100);
    repeat (4) @(negedge wb_clk);
    set_rdy(1'b1);
    wait_idle(100);
    repeat (4) @(negedge wb_clk);
    @(posedge wb_clk);
    #1 spur_en = 1'b0;
    check("spur_rsp_valid", 32'(rsp_valid), 32'd0);

    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
